// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one registered-read, byte-strobed mem port
// One grant at a time: grant cycle drives mem, next cycle captures read data, then a held response.
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  input  logic [NUM_REQ-1:0]                rsp_ready_i,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic                              mem_we_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         prio_q, prio_d;
  logic [IDW-1:0]         gnt_id_q, gnt_id_d;
  logic                   gnt_we_q, gnt_we_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic                   found;
  logic [IDW-1:0]         win;

  // Scan from prio upward with an explicit wrap so non-power-of-2 counts work.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(prio_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_id_d    = gnt_id_q;
    gnt_we_d    = gnt_we_q;
    rsp_data_d  = rsp_data_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;

    case (state_q)
      IDLE: begin
        // Grant is gated by reset so nothing reaches mem while arst_ni is low.
        if (found && arst_ni) begin
          req_ready_o[win] = 1'b1;
          mem_addr_o  = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
          mem_we_o    = req_we_i[win];
          mem_wdata_o = req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
          mem_wstrb_o = req_wstrb_i[win*SW +: SW];
          gnt_id_d    = win;
          gnt_we_d    = req_we_i[win];
          prio_d      = (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
          state_d     = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_data_d = gnt_we_q ? '0 : mem_rdata_i;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid_o[gnt_id_q] = 1'b1;
        rsp_rdata_o           = rsp_data_q;
        if (rsp_ready_i[gnt_id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      prio_q     <= '0;
      gnt_id_q   <= '0;
      gnt_we_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_id_q   <= gnt_id_d;
      gnt_we_q   <= gnt_we_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural mem and reference model
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [SW-1:0]   mem_wstrb;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .arst_ni(arst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
  );

  // Behavioural mem macro: byte-strobed write, registered read.
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < SW; b++)
        if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem_arr[mem_addr];
  end

  logic [DW-1:0] ref_mem [16];

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            rise;
  } exp_t;
  exp_t sb[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            hs_cnt = 0;
  int            acc_cnt = 0;
  int            last_acc_cyc = 0;
  logic [DW-1:0] last_rsp = '0;
  bit            front_seen = 0;
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            g_id;
  logic [AW-1:0] g_addr;
  exp_t          g_e;

  // Monitor: pushes expectations at each handshake, pops and compares at each response.
  always @(negedge clk) begin
    if (!arst_n) begin
      check("reset_ctrl_zero", {req_ready, rsp_valid, mem_we, mem_wstrb, mem_addr}, 64'd0);
      check("reset_data_zero", {rsp_rdata, mem_wdata}, 64'd0);
      sb.delete();
      front_seen = 0;
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 64'd0);
        else begin
          check("rsp_id", rsp_valid, 64'd1 << sb[0].id);
          check("rsp_data", rsp_rdata, sb[0].data);
          check("no_grant_during_rsp", req_ready, 64'd0);
          if (!front_seen) begin
            check("rsp_latency", cyc, sb[0].rise);
            front_seen = 1;
          end
          if (rsp_ready[sb[0].id]) begin
            last_rsp     = rsp_rdata;
            last_acc_cyc = cyc;
            acc_cnt++;
            void'(sb.pop_front());
            front_seen = 0;
          end
        end
      end
      if (req_ready != '0) begin
        check("ready_onehot", $onehot(req_ready), 64'd1);
        g_id = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) g_id = k;
        gnt_log.push_back(g_id);
        gnt_cyc.push_back(cyc);
        g_addr = req_addr[g_id*AW +: AW];
        g_e.id   = g_id;
        g_e.rise = cyc + 2;
        if (req_we[g_id]) begin
          for (int b = 0; b < SW; b++)
            if (req_wstrb[g_id*SW + b]) ref_mem[g_addr][8*b +: 8] = req_wdata[g_id*DW + 8*b +: 8];
          g_e.data = '0;
        end else begin
          g_e.data = ref_mem[g_addr];
        end
        sb.push_back(g_e);
        hs_cnt++;
      end
    end
  end

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_cnt < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (hs_cnt < target) check(name, hs_cnt, target);
  endtask

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (acc_cnt < target) check(name, acc_cnt, target);
  endtask

  task automatic set_req(input int id, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    req_we[id]              = we;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*DW +: DW]  = wd;
    req_wstrb[id*SW +: SW]  = ws;
    req_valid[id]           = 1'b1;
  endtask

  task automatic run_txn(input int id, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    int h, c;
    h = hs_cnt + 1;
    c = acc_cnt + 1;
    set_req(id, we, a, wd, ws);
    wait_hs(h, "txn_grant_timeout");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_acc(c, "txn_rsp_timeout");
  endtask

  typedef struct {
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0, a0;
    int exp_rr[5];
    int exp_23[3];
    int exp_mr[3];

    tbl[0] = '{1, 1'b1, 4'h3, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1, 1'b0, 4'h3, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{0, 1'b1, 4'hB, 32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{0, 1'b1, 4'hB, 32'h000000AA, 4'h1, 32'h0};
    tbl[4] = '{0, 1'b0, 4'hB, 32'h0,        4'h0, 32'h112233AA};
    tbl[5] = '{0, 1'b1, 4'hB, 32'hFFFFFFFF, 4'h0, 32'h0};
    tbl[6] = '{0, 1'b0, 4'hB, 32'h0,        4'h0, 32'h112233AA};
    tbl[7] = '{3, 1'b1, 4'h8, 32'h5A5A0F0F, 4'hF, 32'h0};
    tbl[8] = '{2, 1'b1, 4'h5, 32'hCAFEBABE, 4'hF, 32'h0};
    exp_rr = '{0, 1, 2, 3, 0};
    exp_23 = '{3, 2, 3};
    exp_mr = '{2, 1, 3};

    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      mem_arr[4+i] = 32'h0A0B0C00 | 32'(i);
      ref_mem[4+i] = 32'h0A0B0C00 | 32'(i);
    end

    // Reset with every requester valid, then round-robin over rows 4..7.
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = '1;
    arst_n    = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(4 + i), '0, '0);
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk); #1;
    check("first_grant_after_reset", req_ready, 64'b0001);
    wait_hs(5, "rr_grant_timeout");
    @(posedge clk); #1;
    req_valid = '0;
    wait_acc(5, "rr_rsp_timeout");
    check("rr_grant_count", gnt_log.size(), 64'd5);
    if (gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rr_order", gnt_log[i], exp_rr[i]);
      check("grant_spacing", gnt_cyc[1] - gnt_cyc[0], 64'd3);
    end

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      check($sformatf("vec%0d_rsp", i), last_rsp, tbl[i].exp);
    end

    // Only requesters 2 and 3 valid, prio now 3.
    gnt_log.delete(); gnt_cyc.delete();
    h0 = hs_cnt; a0 = acc_cnt;
    set_req(2, 1'b0, 4'h5, '0, '0);
    set_req(3, 1'b0, 4'h8, '0, '0);
    wait_hs(h0 + 3, "pair_grant_timeout");
    @(posedge clk); #1;
    req_valid = '0;
    wait_acc(a0 + 3, "pair_rsp_timeout");
    check("pair_grant_count", gnt_log.size(), 64'd3);
    if (gnt_log.size() >= 3)
      for (int i = 0; i < 3; i++) check("pair_order", gnt_log[i], exp_23[i]);

    // Back-pressure: requester 1 reads CAFEBABE while requester 2 waits.
    gnt_log.delete(); gnt_cyc.delete();
    h0 = hs_cnt; a0 = acc_cnt;
    rsp_ready[1] = 1'b0;
    set_req(1, 1'b0, 4'h5, '0, '0);
    wait_hs(h0 + 1, "bp_grant_timeout");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(2, 1'b0, 4'h8, '0, '0);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk); #1;
      check("bp_rsp_valid", rsp_valid, 64'b0010);
      check("bp_rdata_stable", rsp_rdata, 64'hCAFEBABE);
      check("bp_no_ready", req_ready, 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    wait_hs(h0 + 2, "bp_next_grant_timeout");
    if (gnt_log.size() >= 2) begin
      check("bp_next_grant_id", gnt_log[1], 64'd2);
      check("bp_next_grant_cycle", gnt_cyc[1], last_acc_cyc + 1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_acc(a0 + 2, "bp_rsp_timeout");
    check("bp_second_rsp", last_rsp, 64'h5A5A0F0F);

    // Reset during CAPTURE of a read; prio must return to 0.
    gnt_log.delete(); gnt_cyc.delete();
    h0 = hs_cnt; a0 = acc_cnt;
    set_req(2, 1'b0, 4'h8, '0, '0);
    wait_hs(h0 + 1, "mr_grant_timeout");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    arst_n = 1'b0;
    set_req(1, 1'b0, 4'h8, '0, '0);
    set_req(3, 1'b0, 4'h8, '0, '0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk); #1;
    check("mr_prio_reset", req_ready, 64'b0010);
    wait_hs(h0 + 3, "mr_regrant_timeout");
    @(posedge clk); #1;
    req_valid = '0;
    wait_acc(a0 + 2, "mr_rsp_timeout");
    repeat (4) @(negedge clk);
    check("mr_rsp_count", acc_cnt, a0 + 2);
    check("mr_committed_write", last_rsp, 64'h5A5A0F0F);
    check("mr_grant_count", gnt_log.size(), 64'd3);
    if (gnt_log.size() >= 3)
      for (int i = 0; i < 3; i++) check("mr_order", gnt_log[i], exp_mr[i]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
